// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the shift-and-add sequencer and its datapath/user side.
// Latency: pure wiring, none.
// Backpressure: none; start/ack are levels, sampled only in the states that care.
interface mult_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  logic          start;
  logic          ack;
  logic          q0;
  logic          ld_q;
  logic          sh_q;
  logic          ld_m;
  logic          clr_a;
  logic          add_a;
  logic          sh_a;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  // Sequencer side: consumes user levels and the Q LSB, drives datapath strobes.
  modport master (
    input  start, ack, q0,
    output ld_q, sh_q, ld_m, clr_a, add_a, sh_a, busy, done, cnt
  );

  // Datapath/user side: mirror image of the sequencer view.
  modport slave (
    output start, ack, q0,
    input  ld_q, sh_q, ld_m, clr_a, add_a, sh_a, busy, done, cnt
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for an N-bit shift-and-add multiplier (Qreg, accumulator A, M).
// Latency: done rises 1+2N+popcount(multiplier) cycles after start is sampled.
// Backpressure: result held in DONE until ack; start ignored while a run is active.
module mult_seq_ctrl #(
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input logic             clk,
  input logic             rst,
  mult_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic ld_q;
  logic sh_q;
  logic ld_m;
  logic clr_a;
  logic add_a;
  logic sh_a;
  logic busy;
  logic done;

  // State and remaining-iteration registers; reset aborts any run in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and counter from inputs; strobes decoded from state alone so
  // no input ever reaches an output combinationally.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_q     = 1'b0;
    sh_q     = 1'b0;
    ld_m     = 1'b0;
    clr_a    = 1'b0;
    add_a    = 1'b0;
    sh_a     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_nx = LOAD;
      end

      LOAD: begin
        ld_q     = 1'b1;
        ld_m     = 1'b1;
        clr_a    = 1'b1;
        busy     = 1'b1;
        cnt_nx   = CW'(N);
        state_nx = EVAL;
      end

      EVAL: begin
        busy     = 1'b1;
        state_nx = bus.q0 ? ADD : SHIFT;
      end

      ADD: begin
        add_a    = 1'b1;
        busy     = 1'b1;
        state_nx = SHIFT;
      end

      SHIFT: begin
        sh_q = 1'b1;
        sh_a = 1'b1;
        busy = 1'b1;
        // Guarded so a corrupted zero count cannot wrap to all-ones.
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        state_nx = (cnt > CW'(1)) ? EVAL : DONE;
      end

      DONE: begin
        done = 1'b1;
        if (bus.ack) state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.ld_q  = ld_q;
  assign bus.sh_q  = sh_q;
  assign bus.ld_m  = ld_m;
  assign bus.clr_a = clr_a;
  assign bus.add_a = add_a;
  assign bus.sh_a  = sh_a;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.cnt   = cnt;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural Qreg/A/M datapath driven by its strobes.
// Expected products are queued when a run starts and popped when done is seen.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_mult_seq_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] sw_q = '0;
  logic [N-1:0] sw_m = '0;

  mult_seq_ctrl_if #(.N(N)) bus ();
  mult_seq_ctrl #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [2*N-1:0] exp_q [$];

  // Datapath model: Q, A, carry C and M react to the sequencer strobes.
  logic [N-1:0] m_q = '0;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_m = '0;
  logic         m_c = 1'b0;

  always @(posedge clk) begin
    if (bus.ld_q) m_q <= sw_q;
    if (bus.ld_m) m_m <= sw_m;
    if (bus.clr_a) begin
      m_a <= '0;
      m_c <= 1'b0;
    end
    if (bus.add_a) {m_c, m_a} <= {1'b0, m_a} + {1'b0, m_m};
    if (bus.sh_q) begin
      m_q <= {m_a[0], m_q[N-1:1]};
      m_a <= {m_c, m_a[N-1:1]};
      m_c <= 1'b0;
    end
  end

  assign bus.q0 = m_q[0];

  // {ld_q, sh_q, ld_m, clr_a, add_a, sh_a, busy, done}
  logic [7:0] ctl;
  assign ctl = {bus.ld_q, bus.sh_q, bus.ld_m, bus.clr_a, bus.add_a, bus.sh_a, bus.busy, bus.done};

  localparam logic [7:0] CTL_IDLE = 8'h00;
  localparam logic [7:0] CTL_LOAD = 8'hB2;
  localparam logic [7:0] CTL_DONE = 8'h01;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands and start, queue the expected product, land on the LOAD sample.
  task automatic start_op(input logic [N-1:0] qv, input logic [N-1:0] mv);
    logic [2*N-1:0] p;
    p = (2*N)'(qv) * (2*N)'(mv);
    sw_q = qv;
    sw_m = mv;
    bus.start = 1'b1;
    exp_q.push_back(p);
    step();
  endtask

  // Walk from the LOAD sample to the DONE sample, tallying strobes and the cnt trace.
  task automatic run_to_done(input bit mid_pulse, input bit keep_start,
                             output int lat, output int loads, output int adds,
                             output int shifts, output int bad,
                             output logic [19:0] trace, output bit tout);
    int cyc;
    logic [3:0] last;
    cyc = 0; lat = 0; loads = 0; adds = 0; shifts = 0; bad = 0;
    trace = '0; tout = 1'b0; last = 4'hF;
    while (bus.done !== 1'b1 && cyc < 60) begin
      if (bus.ld_q === 1'b1) loads++;
      if (bus.add_a === 1'b1) adds++;
      if (bus.sh_q === 1'b1) shifts++;
      if (bus.sh_q !== bus.sh_a || bus.ld_q !== bus.ld_m || bus.ld_q !== bus.clr_a) bad++;
      if ((int'(bus.ld_q) + int'(bus.add_a) + int'(bus.sh_q)) > 1) bad++;
      if (bus.busy !== 1'b1) bad++;
      if (cyc == 0 && bus.ld_q !== 1'b1) bad++;
      if ({1'b0, bus.cnt} != last) begin
        last  = {1'b0, bus.cnt};
        trace = {trace[15:0], last};
      end
      if (!keep_start) bus.start = mid_pulse ? cyc[0] : 1'b0;
      step();
      cyc++;
    end
    if ({1'b0, bus.cnt} != last) trace = {trace[15:0], 1'b0, bus.cnt};
    lat  = cyc;
    tout = (bus.done !== 1'b1);
    if (!keep_start) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.ack   = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (ctl !== CTL_IDLE || bus.cnt !== '0) begin
        n_err++;
        $display("FAIL reset_held cyc %0d: ctl=%h cnt=%0d, want ctl=%h cnt=0", i, ctl, bus.cnt, CTL_IDLE);
      end
    end
    rst = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (ctl !== CTL_IDLE || bus.cnt !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: ctl=%h cnt=%0d, want ctl=%h cnt=0", i, ctl, bus.cnt, CTL_IDLE);
      end
    end
  endtask

  task automatic test_multiply(input logic [N-1:0] qv, input logic [N-1:0] mv);
    int lat, loads, adds, shifts, bad, pc;
    logic [19:0] trace;
    logic [2*N-1:0] want;
    bit tout;
    pc = $countones(qv);
    start_op(qv, mv);
    run_to_done(1'b0, 1'b0, lat, loads, adds, shifts, bad, trace, tout);
    n_vec++;
    if (tout || lat != 1 + 2*N + pc) begin
      n_err++;
      $display("FAIL mul_latency %0dx%0d: got %0d (timeout=%0d), want %0d", qv, mv, lat, tout, 1 + 2*N + pc);
    end
    n_vec++;
    if (loads != 1 || adds != pc || shifts != N || bad != 0) begin
      n_err++;
      $display("FAIL mul_strobes %0dx%0d: load=%0d add=%0d shift=%0d bad=%0d, want 1 %0d %0d 0",
               qv, mv, loads, adds, shifts, bad, pc, N);
    end
    n_vec++;
    if (trace !== 20'h43210) begin
      n_err++;
      $display("FAIL mul_cnt_trace %0dx%0d: got %h, want 43210", qv, mv, trace);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL mul_scoreboard %0dx%0d: got empty queue, want one entry", qv, mv);
    end else begin
      want = exp_q.pop_front();
      if ({m_a, m_q} !== want || ctl !== CTL_DONE) begin
        n_err++;
        $display("FAIL mul_result %0dx%0d: got %h ctl=%h, want %h ctl=%h", qv, mv, {m_a, m_q}, ctl, want, CTL_DONE);
      end
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_vec++;
    if (ctl !== CTL_IDLE || bus.cnt !== '0) begin
      n_err++;
      $display("FAIL mul_release %0dx%0d: ctl=%h cnt=%0d, want ctl=%h cnt=0", qv, mv, ctl, bus.cnt, CTL_IDLE);
    end
  endtask

  task automatic test_handshake();
    int lat, loads, adds, shifts, bad;
    logic [19:0] trace;
    logic [2*N-1:0] want;
    bit tout;
    int held_bad;
    start_op(4'd10, 4'd6);
    run_to_done(1'b1, 1'b0, lat, loads, adds, shifts, bad, trace, tout);
    n_vec++;
    if (tout || lat != 1 + 2*N + 2 || loads != 1 || adds != 2 || bad != 0) begin
      n_err++;
      $display("FAIL hs_midstart: lat=%0d load=%0d add=%0d bad=%0d tout=%0d, want %0d 1 2 0 0",
               lat, loads, adds, bad, tout, 1 + 2*N + 2);
    end
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ctl !== CTL_DONE) held_bad++;
    end
    n_vec++;
    if (held_bad != 0) begin
      n_err++;
      $display("FAIL hs_hold: got %0d cycles off DONE (last ctl=%h), want 0", held_bad, ctl);
    end
    n_vec++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({m_a, m_q} !== want) begin
      n_err++;
      $display("FAIL hs_result: got %h, want %h", {m_a, m_q}, want);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_vec++;
    if (ctl !== CTL_IDLE) begin
      n_err++;
      $display("FAIL hs_ack: ctl=%h, want %h", ctl, CTL_IDLE);
    end
  endtask

  task automatic test_abort();
    int shifts;
    int cyc;
    shifts = 0;
    cyc = 0;
    start_op(4'd3, 4'd3);
    bus.start = 1'b0;
    while (cyc < 40) begin
      if (bus.sh_q === 1'b1) shifts++;
      if (shifts == 2) break;
      step();
      cyc++;
    end
    n_vec++;
    if (shifts != 2) begin
      n_err++;
      $display("FAIL abort_reach: got %0d shifts, want 2", shifts);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (ctl !== CTL_IDLE || bus.cnt !== '0) begin
      n_err++;
      $display("FAIL abort_async: ctl=%h cnt=%0d, want ctl=%h cnt=0", ctl, bus.cnt, CTL_IDLE);
    end
    exp_q.delete();
    step();
    rst = 1'b1;
    step();
    n_vec++;
    if (ctl !== CTL_IDLE) begin
      n_err++;
      $display("FAIL abort_idle: ctl=%h, want %h", ctl, CTL_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int lat, loads, adds, shifts, bad;
    logic [19:0] trace;
    logic [2*N-1:0] want;
    bit tout;
    bus.ack = 1'b1;
    start_op(4'd6, 4'd11);
    run_to_done(1'b0, 1'b1, lat, loads, adds, shifts, bad, trace, tout);
    n_vec++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if (tout || lat != 1 + 2*N + 2 || {m_a, m_q} !== want) begin
      n_err++;
      $display("FAIL b2b_first: lat=%0d result=%h, want %0d %h", lat, {m_a, m_q}, 1 + 2*N + 2, want);
    end
    sw_q = 4'd9;
    sw_m = 4'd13;
    exp_q.push_back(8'(4'd9) * 8'(4'd13));
    step();
    n_vec++;
    if (ctl !== CTL_IDLE) begin
      n_err++;
      $display("FAIL b2b_gap: ctl=%h, want %h", ctl, CTL_IDLE);
    end
    step();
    n_vec++;
    if (ctl !== CTL_LOAD) begin
      n_err++;
      $display("FAIL b2b_reload: ctl=%h, want %h", ctl, CTL_LOAD);
    end
    run_to_done(1'b0, 1'b1, lat, loads, adds, shifts, bad, trace, tout);
    n_vec++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if (tout || lat != 1 + 2*N + 2 || {m_a, m_q} !== want || bad != 0) begin
      n_err++;
      $display("FAIL b2b_second: lat=%0d result=%h bad=%0d, want %0d %h 0", lat, {m_a, m_q}, bad, 1 + 2*N + 2, want);
    end
    bus.start = 1'b0;
    step();
    bus.ack = 1'b0;
    n_vec++;
    if (ctl !== CTL_IDLE) begin
      n_err++;
      $display("FAIL b2b_end: ctl=%h, want %h", ctl, CTL_IDLE);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    test_reset();
    test_multiply(4'd7, 4'd5);
    test_multiply(4'd0, 4'd15);
    test_multiply(4'd15, 4'd15);
    test_handshake();
    test_abort();
    test_multiply(4'd3, 4'd3);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Moore FSM that sequences the shift-and-add multiplier datapath built around Qreg (multiplier/Q register), the accumulator A, and the multiplicand register M.
- Loads operands from switches, iterates N add/shift steps on the Q LSB, then holds a done/ack handshake.
- Sits between the top-level user inputs (start/ack) and the Qreg/A/M control pins.

Parameters:
- N, 4, operand width in bits; also the iteration count. Legal range is N >= 2.
- CW, $clog2(N+1), iteration counter width. Derived parameter; do not override.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE; 1 begins a multiply.
- ack  in  1  level; sampled only in DONE; 1 releases the result.
- q0  in  1  Qout[0] from Qreg (current multiplier LSB).
- ld_q  out  1  to Qreg ldp; parallel-load Q from SW.
- sh_q  out  1  to Qreg cta; shift Q right one bit.
- ld_m  out  1  load M from operand switches.
- clr_a  out  1  clear accumulator A and carry.
- add_a  out  1  A <= A + M (carry captured).
- sh_a  out  1  shift {C,A} right into Q MSB. Always asserted together with sh_q.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  result valid in {A,Q}.
- cnt  out  CW  remaining iterations, for debug and LEDs.

Behaviour:
- States: IDLE, LOAD, EVAL, ADD, SHIFT, DONE. Encoding is free. All outputs are decoded from the state register only (Moore, no input-to-output paths).
- Reset (rst=0, asynchronous): state=IDLE, cnt=0. All outputs are 0 while reset is held and after release. Reset asserted mid-operation aborts immediately; datapath contents are don't-care.
- IDLE: all controls 0. start=1 at an edge -> LOAD.
- LOAD (1 cycle): ld_q=ld_m=clr_a=1; cnt<=N -> EVAL.
- EVAL (1 cycle): no datapath strobes. q0=1 -> ADD; q0=0 -> SHIFT. q0 is sampled at the EVAL->next edge.
- ADD (1 cycle): add_a=1 -> SHIFT.
- SHIFT (1 cycle): sh_q=sh_a=1; cnt<=cnt-1.
  - If cnt==1 on entry -> DONE.
  - Otherwise -> EVAL.
- DONE: done=1, busy=0. Held indefinitely until ack=1 at an edge -> IDLE. cnt stays 0.
- Exactly one datapath strobe group is active per cycle: ld_* and clr_a only in LOAD, add_a only in ADD, sh_* only in SHIFT.
- Latency: done first samples high 1+2N+P cycles after the edge that sampled start, where P = popcount of the loaded multiplier.
  - N=4: range 9..13 cycles.
- start is ignored outside IDLE; a multiply cannot be restarted mid-operation.
- ack is ignored outside DONE.
- start and ack both high in DONE: go to IDLE. If start is still high, the next edge goes to LOAD, so back-to-back operation costs exactly 1 IDLE cycle.
- start held high continuously: runs repeat, each separated by DONE->(ack)->IDLE.
- cnt never wraps; SHIFT is never entered with cnt=0.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 -> all outputs 0 and state IDLE; after release with start=0, IDLE holds for 10 cycles with no strobes.
- Multiply 7x5 (N=4, bench model of Qreg/A/M, q0 from the model) -> one LOAD cycle, 3 ADD cycles, 4 SHIFT cycles. done rises 12 cycles after start is sampled; {A,Q}=8'h23; cnt sequence 4,3,2,1,0.
- Multiplier 0 and multiplier 15 (M=15) -> no ADD, done at cycle 9, result 0; then 4 ADDs, done at cycle 13, result 8'hE1.
- Handshake: hold ack=0 for 20 cycles in DONE -> done stays 1 with no strobes. ack=1 -> IDLE next cycle. start pulsed during EVAL/ADD/SHIFT -> no effect.
- Abort: pull rst low during the second SHIFT -> outputs 0 immediately (asynchronous). After release, a fresh 3x3 run completes with result 9.
- Back-to-back: start and ack tied high -> LOAD recurs exactly 1 IDLE cycle after each DONE; results are correct for two consecutive operand pairs.
